// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, FSM states,
// ALUOp codes, mux select constants and the bundled control word.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_ADDI  = 6'd8;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_SEXT    = 2'b10;
   localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADDR   = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXECUTE   = 4'd6,
      S_RCOMPLETE = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDIEXEC  = 4'd10,
      S_ADDIWB    = 4'd11,
      S_IDLE      = 4'd15
   } state_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       ir_write;
      logic [1:0] pc_source;
      logic [1:0] alu_op;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       reg_dst;
      logic       illegal_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath.
// Define ADDI_EN to add the addi execute/writeback states (op 8).
module multicycle_control
   import mips_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   state_e state_q, state_d;
   ctrl_t  ctrl;

   // Dispatch target out of DECODE; S_FETCH marks an unsupported opcode.
   function automatic state_e decode_target(input logic [5:0] opc);
      case (opc)
         OP_LW, OP_SW: return S_MEMADDR;
         OP_RTYPE:     return S_EXECUTE;
         OP_BEQ:       return S_BRANCH;
         OP_J:         return S_JUMP;
`ifdef ADDI_EN
         OP_ADDI:      return S_ADDIEXEC;
`endif
         default:      return S_FETCH;
      endcase
   endfunction

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: default assignment first so no path through the case leaves a latch.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_IDLE:      state_d = S_FETCH;
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE:    state_d = decode_target(op);
         S_MEMADDR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:   state_d = mem_ready ? S_MEMWB : S_MEMREAD;
         S_MEMWB:     state_d = S_FETCH;
         S_MEMWRITE:  state_d = mem_ready ? S_FETCH : S_MEMWRITE;
         S_EXECUTE:   state_d = S_RCOMPLETE;
         S_RCOMPLETE: state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
`ifdef ADDI_EN
         S_ADDIEXEC:  state_d = S_ADDIWB;
         S_ADDIWB:    state_d = S_FETCH;
`endif
         default:     state_d = S_FETCH;
      endcase
   end

   always_comb begin
      ctrl = '0;
      case (state_q)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_source = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = SRCB_SEXT_SH;
            ctrl.alu_op     = ALUOP_ADD;
            ctrl.illegal_op = (decode_target(op) == S_FETCH);
         end
         S_MEMADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_RCOMPLETE: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_src_b     = SRCB_REG;
            ctrl.alu_op        = ALUOP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = PCSRC_JUMP;
         end
`ifdef ADDI_EN
         S_ADDIEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_SEXT;
            ctrl.alu_op    = ALUOP_ADD;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
`endif
         default: ctrl = '0;
      endcase
   end

   assign PCWrite     = ctrl.pc_write;
   assign PCWriteCond = ctrl.pc_write_cond;
   assign IorD        = ctrl.i_or_d;
   assign MemRead     = ctrl.mem_read;
   assign MemWrite    = ctrl.mem_write;
   assign MemtoReg    = ctrl.mem_to_reg;
   assign IRWrite     = ctrl.ir_write;
   assign PCSource    = ctrl.pc_source;
   assign ALUOp       = ctrl.alu_op;
   assign ALUSrcA     = ctrl.alu_src_a;
   assign ALUSrcB     = ctrl.alu_src_b;
   assign RegWrite    = ctrl.reg_write;
   assign RegDst      = ctrl.reg_dst;
   assign illegal_op  = ctrl.illegal_op;
   assign state_o     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: each driven cycle pushes its expected
// state and control word; a negedge monitor pops and compares.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic [1:0] PCSource, ALUOp, ALUSrcB;
   logic       ALUSrcA, RegWrite, RegDst, illegal_op;
   logic [3:0] state_o;

   typedef struct packed {
      logic       pcw, pcwc, iord, mrd, mwr, m2r, irw;
      logic [1:0] pcs, aluop;
      logic       srca;
      logic [1:0] srcb;
      logic       rw, rdst, ill;
   } outs_t;

   typedef struct {
      logic [3:0] st;
      outs_t      v;
   } exp_t;

   exp_t  exp_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   outs_t got_v;

   always #5 clk = ~clk;

   multicycle_control dut (
      .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .illegal_op(illegal_op), .state_o(state_o)
   );

   assign got_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic legal_op(input logic [5:0] o);
`ifdef ADDI_EN
      return (o == 6'd0 || o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd2 || o == 6'd8);
`else
      return (o == 6'd0 || o == 6'd35 || o == 6'd43 || o == 6'd4 || o == 6'd2);
`endif
   endfunction

   function automatic outs_t exp_vec(input logic [3:0] st, input logic [5:0] o, input logic mr);
      outs_t e;
      e = '0;
      case (st)
         4'd0: begin e.mrd = 1'b1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr; end
         4'd1: begin e.srcb = 2'b11; e.ill = !legal_op(o); end
         4'd2: begin e.srca = 1'b1; e.srcb = 2'b10; end
         4'd3: begin e.mrd = 1'b1; e.iord = 1'b1; end
         4'd4: begin e.rw = 1'b1; e.m2r = 1'b1; end
         4'd5: begin e.mwr = 1'b1; e.iord = 1'b1; end
         4'd6: begin e.srca = 1'b1; e.aluop = 2'b10; end
         4'd7: begin e.rw = 1'b1; e.rdst = 1'b1; end
         4'd8: begin e.srca = 1'b1; e.aluop = 2'b01; e.pcwc = 1'b1; e.pcs = 2'b01; end
         4'd9: begin e.pcw = 1'b1; e.pcs = 2'b10; end
`ifdef ADDI_EN
         4'd10: begin e.srca = 1'b1; e.srcb = 2'b10; end
         4'd11: begin e.rw = 1'b1; end
`endif
         default: e = '0;
      endcase
      return e;
   endfunction

   // One clock of stimulus; its expected response is queued for the monitor.
   task automatic cyc(input logic [3:0] st, input logic [5:0] o, input logic mr,
                      input logic rs = 1'b0);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rs;
      op        = o;
      mem_ready = mr;
      e.st = st;
      e.v  = rs ? outs_t'('0) : exp_vec(st, o, mr);
      exp_q.push_back(e);
   endtask

   // Full instruction: fetch waits, decode, then the op-specific states.
   // mem_ready is randomised wherever the FSM must ignore it.
   task automatic instr(input logic [5:0] o, input int fetch_wait, input int mem_wait);
      repeat (fetch_wait) cyc(4'd0, o, 1'b0);
      cyc(4'd0, o, 1'b1);
      cyc(4'd1, o, 1'($urandom_range(1)));
      case (o)
         6'd35: begin
            cyc(4'd2, o, 1'($urandom_range(1)));
            repeat (mem_wait) cyc(4'd3, o, 1'b0);
            cyc(4'd3, o, 1'b1);
            cyc(4'd4, o, 1'($urandom_range(1)));
         end
         6'd43: begin
            cyc(4'd2, o, 1'($urandom_range(1)));
            repeat (mem_wait) cyc(4'd5, o, 1'b0);
            cyc(4'd5, o, 1'b1);
         end
         6'd0: begin
            cyc(4'd6, o, 1'($urandom_range(1)));
            cyc(4'd7, o, 1'($urandom_range(1)));
         end
         6'd4: cyc(4'd8, o, 1'($urandom_range(1)));
         6'd2: cyc(4'd9, o, 1'($urandom_range(1)));
`ifdef ADDI_EN
         6'd8: begin
            cyc(4'd10, o, 1'($urandom_range(1)));
            cyc(4'd11, o, 1'($urandom_range(1)));
         end
`endif
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check($sformatf("state(exp %0d)", e.st), 32'(state_o), 32'(e.st));
         check($sformatf("ctrl(st %0d)", e.st), 32'(got_v), 32'(e.v));
      end
   end

   initial begin
      reset     = 1'b1;
      op        = 6'd0;
      mem_ready = 1'b0;

      repeat (3) cyc(4'd15, 6'd0, 1'b1, 1'b1);
      cyc(4'd15, 6'd35, 1'b1);

      instr(6'd35, 0, 0);
      instr(6'd0,  0, 0);
      instr(6'd43, 0, 3);
      instr(6'd4,  0, 0);
      instr(6'd2,  0, 0);
      instr(6'd63, 0, 0);
      instr(6'd35, 2, 2);
      instr(6'd8,  0, 0);
      instr(6'd1,  1, 0);

      // Reset while holding in MEMREAD.
      cyc(4'd0, 6'd35, 1'b1);
      cyc(4'd1, 6'd35, 1'b1);
      cyc(4'd2, 6'd35, 1'b0);
      cyc(4'd3, 6'd35, 1'b0);
      cyc(4'd15, 6'd35, 1'b1, 1'b1);
      cyc(4'd15, 6'd0, 1'b1);
      instr(6'd0, 0, 0);

      @(negedge clk);
      #1;
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
